buffer_to_mpf_sm_matrix: RTL and testbench
==========================================

BUFFER_TO_MPF_SM_MATRIX -- requirements
Module: buffer_to_mpf_sm_matrix

Interface
REQ-001 SHALL have parameter WR_MDATA, default 'd2, mdata tag carried on every write request.
REQ-002 SHALL have port clk, input, 1 bit: sole clock, all state on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port run, input, 1 bit: a 1-cycle pulse starts writing the result matrix C.
REQ-005 SHALL have port M, input, 32 bits: rows of C.
REQ-006 SHALL have port N, input, 32 bits: columns of C in 32-bit elements; N_cl = N>>4 lines per row, low 4 bits ignored.
REQ-007 SHALL have port first_clAddr_C, input, t_cci_clAddr: base virtual line address of C, held stable while not done.
REQ-008 SHALL have port done, output, 1 bit: high iff state is IDLE.
REQ-009 SHALL have port c1TxAlmFull, input, 1 bit: FIU write channel almost full.
REQ-010 SHALL have port c1TxValid, output, 1 bit, registered: write request valid.
REQ-011 SHALL have port reqMemHdr, output, CCI_MPF_C1TX_MEMHDR_WIDTH bits, registered: MPF write header.
REQ-012 SHALL have port c1TxData, output, 512 bits, registered: write payload.
REQ-013 SHALL have port c1Rx, input, t_if_ccip_c1_Rx: write and fence responses.
REQ-014 SHALL have port buffer_empty, input, 1 bit: result buffer (show-ahead FIFO) holds no line.
REQ-015 SHALL have port buffer_data, input, 512 bits: head line, valid whenever buffer_empty is low.
REQ-016 SHALL have port buffer_rd_enable, output, 1 bit, combinational: pops the buffer head.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on run; RUN->DRAIN when the last request has issued; DRAIN->IDLE when all responses have arrived (REQ-024).
REQ-018 SHALL ignore run outside IDLE.
REQ-019 SHALL on run clear the counters line, col, nwr_rq and nwr_resp, and the requests_done flag.
REQ-020 SHALL assert issue = (state==RUN) && !c1TxAlmFull && !buffer_empty && !requests_done, with buffer_rd_enable = issue.
REQ-021 SHALL on issue register, one cycle later: c1TxValid=1, c1TxData=buffer_data, and an eREQ_WRLINE_M header.
  - Header fields: eVC_VA, eCL_LEN_1, virtual addressing, sop=1, mdata=WR_MDATA, address first_clAddr_C + N_cl*line + col.
  - Address arithmetic SHALL be computed modulo the t_cci_clAddr width.
REQ-022 SHALL advance col on issue; when col==N_cl-1, col wraps to 0 and line increments; when line==M-1 at that point, requests_done is set.
REQ-023 SHALL count nwr_rq on c1TxValid and nwr_resp on each cci_c1Rx_isWriteRsp response with matching mdata; a response and a request in the same cycle SHALL both count.
REQ-024 SHALL treat completion as requests_done && nwr_resp==nwr_rq (plus the fence condition, REQ-029).
REQ-025 SHALL, when M==0 or N_cl==0, issue no requests and return to IDLE within 2 cycles of run.
REQ-026 SHALL hold c1TxValid low whenever no issue occurred in the previous cycle; the buffer SHALL never be popped while empty.

Reset
REQ-027 SHALL, on reset assertion (asynchronous, any cycle including mid-transfer), force the following:
  - state=IDLE, done=1;
  - c1TxValid=0, reqMemHdr=0, c1TxData=0;
  - all counters and requests_done cleared.
  Outstanding responses arriving after reset SHALL be ignored.

Configuration
REQ-028 SHALL support macro BUF2MPF_WRFENCE_EN.
REQ-029 SHALL, with BUF2MPF_WRFENCE_EN defined, behave as follows after the final write issues:
  - issue one eREQ_WRFENCE (mdata=WR_MDATA) as soon as c1TxAlmFull is low;
  - leave DRAIN only when completion holds and the fence response (cci_c1Rx_isWriteFenceRsp) has been received;
  - exclude the fence from nwr_rq.
REQ-030 SHALL, without the macro, issue no fence and use REQ-024 alone.

Structure
REQ-031 SHALL take t_state (IDLE/RUN/DRAIN) and the constant ELEMS_PER_CL=16 from shared package matrix_mult_pkg.
REQ-032 SHALL place the line/col counters and address computation in sub-module matrix_addr_gen, reusable by the read-side state machine.

Verification
REQ-033 SHALL cover: M=2, N=32, buffer pre-filled with 4 lines, base 0x1000 -> 4 writes to 0x1000, 0x1001, 0x1002, 0x1003 in order with matching data; done rises after the 4th response.
REQ-034 SHALL cover: c1TxAlmFull held high for 5 cycles mid-transfer -> no c1TxValid during those cycles; all lines written once; no pop while AlmFull is high.
REQ-035 SHALL cover: buffer empty after 1 of 3 lines, refilled 10 cycles later -> exactly 3 writes, no duplicates, no pop while empty.
REQ-036 SHALL cover: M=0, N=64 -> zero writes; done back to 1 within 2 cycles.
REQ-037 SHALL cover: reset asserted mid-transfer with 2 writes outstanding -> outputs at reset values immediately; a subsequent run with M=1, N=16 writes 1 line correctly.
REQ-038 SHALL cover, with BUF2MPF_WRFENCE_EN: M=1, N=16 -> 1 write then 1 fence; done stays 0 until the fence response arrives, even after the write response.

Source files
------------

// File: rtl/matrix_mult_pkg.sv
// Shared types for the matrix-multiply MPF front end: FSM states,
// CCI-P/MPF write-channel header, response and address types.
package matrix_mult_pkg;

    localparam int ELEMS_PER_CL = 16;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} t_state;

    typedef logic [41:0]  t_cci_clAddr;
    typedef logic [15:0]  t_cci_mdata;
    typedef logic [511:0] t_cci_clData;

    typedef enum logic [1:0] {
        eVC_VA, eVC_VL0, eVC_VH0, eVC_VH1
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef enum logic [3:0] {
        eRSP_WRLINE  = 4'h0,
        eRSP_WRFENCE = 4'h4,
        eRSP_INTR    = 4'h6
    } t_ccip_c1_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic         sop;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic         addr_is_virtual;
        t_cci_clAddr  address;
        t_cci_mdata   mdata;
    } t_cci_mpf_c1_ReqMemHdr;

    localparam int CCI_MPF_C1TX_MEMHDR_WIDTH = $bits(t_cci_mpf_c1_ReqMemHdr);

    typedef struct packed {
        logic         rspValid;
        t_ccip_c1_rsp resp_type;
        t_cci_mdata   mdata;
    } t_if_ccip_c1_Rx;

    function automatic logic cci_c1Rx_isWriteRsp(t_if_ccip_c1_Rx r);
        return r.rspValid && (r.resp_type == eRSP_WRLINE);
    endfunction

    function automatic logic cci_c1Rx_isWriteFenceRsp(t_if_ccip_c1_Rx r);
        return r.rspValid && (r.resp_type == eRSP_WRFENCE);
    endfunction

    function automatic t_cci_mpf_c1_ReqMemHdr mk_wr_hdr(
        t_cci_clAddr addr, t_cci_mdata md);
        t_cci_mpf_c1_ReqMemHdr h;
        h = '0;
        h.vc_sel          = eVC_VA;
        h.sop             = 1'b1;
        h.cl_len          = eCL_LEN_1;
        h.req_type        = eREQ_WRLINE_M;
        h.addr_is_virtual = 1'b1;
        h.address         = addr;
        h.mdata           = md;
        return h;
    endfunction

    function automatic t_cci_mpf_c1_ReqMemHdr mk_fence_hdr(t_cci_mdata md);
        t_cci_mpf_c1_ReqMemHdr h;
        h = '0;
        h.vc_sel   = eVC_VA;
        h.req_type = eREQ_WRFENCE;
        h.mdata    = md;
        return h;
    endfunction

endpackage

// File: rtl/buffer_to_mpf_sm_matrix_if.sv
// MPF write channel plus result-buffer pop port for the C-matrix writer.
interface buffer_to_mpf_sm_matrix_if;
    import matrix_mult_pkg::*;

    logic                  c1TxAlmFull;
    logic                  c1TxValid;
    t_cci_mpf_c1_ReqMemHdr reqMemHdr;
    t_cci_clData           c1TxData;
    t_if_ccip_c1_Rx        c1Rx;
    logic                  buffer_empty;
    t_cci_clData           buffer_data;
    logic                  buffer_rd_enable;

    modport master (
        input  c1TxAlmFull, c1Rx, buffer_empty, buffer_data,
        output c1TxValid, reqMemHdr, c1TxData, buffer_rd_enable
    );

    modport slave (
        output c1TxAlmFull, c1Rx, buffer_empty, buffer_data,
        input  c1TxValid, reqMemHdr, c1TxData, buffer_rd_enable
    );

endinterface

// File: rtl/matrix_addr_gen.sv
// Row/column line walker over an M x N_cl matrix; shared by read and
// write state machines.
module matrix_addr_gen
    import matrix_mult_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        step,
    input  logic [31:0] M,
    input  logic [31:0] N_cl,
    input  t_cci_clAddr base,
    output t_cci_clAddr addr,
    output logic        last
);

    logic [31:0] line;
    logic [31:0] col;
    t_cci_clAddr row_off;
    logic        col_wrap;

    // row_off tracks N_cl*line incrementally, so no multiplier is needed
    assign col_wrap = (col == N_cl - 32'd1);
    assign last     = col_wrap && (line == M - 32'd1);
    assign addr     = base + row_off + t_cci_clAddr'(col);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line    <= '0;
            col     <= '0;
            row_off <= '0;
        end else if (clear) begin
            line    <= '0;
            col     <= '0;
            row_off <= '0;
        end else if (step) begin
            if (col_wrap) begin
                col     <= '0;
                line    <= line + 32'd1;
                row_off <= row_off + t_cci_clAddr'(N_cl);
            end else begin
                col <= col + 32'd1;
            end
        end
    end

endmodule

// File: rtl/buffer_to_mpf_sm_matrix.sv
// Streams result lines from the show-ahead buffer to MPF as C writes.
// Define BUF2MPF_WRFENCE_EN to append a write fence after the last line.
module buffer_to_mpf_sm_matrix
    import matrix_mult_pkg::*;
#(
    parameter int WR_MDATA = 'd2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        run,
    input  logic [31:0]                 M,
    input  logic [31:0]                 N,
    input  t_cci_clAddr                 first_clAddr_C,
    output logic                        done,
    buffer_to_mpf_sm_matrix_if.master   mpf
);

    t_state      state;
    t_state      state_nxt;
    logic [31:0] n_cl;
    logic [31:0] nwr_rq;
    logic [31:0] nwr_resp;
    logic        requests_done;
    logic        issue;
    logic        last;
    logic        start;
    logic        zero_dim;
    logic        complete;
    logic        wr_rsp;
    logic        fence_issue;
    logic        tx_is_fence;
    t_cci_clAddr wr_addr;
    t_cci_mdata  tag;

    assign tag      = t_cci_mdata'(WR_MDATA);
    assign n_cl     = N >> $clog2(ELEMS_PER_CL);
    assign zero_dim = (M == 32'd0) || (n_cl == 32'd0);
    assign start    = (state == IDLE) && run;
    assign done     = (state == IDLE);
    assign issue    = (state == RUN) && !mpf.c1TxAlmFull
                   && !mpf.buffer_empty && !requests_done;
    assign mpf.buffer_rd_enable = issue;
    assign wr_rsp   = cci_c1Rx_isWriteRsp(mpf.c1Rx)
                   && (mpf.c1Rx.mdata == tag);

    matrix_addr_gen u_addr_gen (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .step  (issue),
        .M     (M),
        .N_cl  (n_cl),
        .base  (first_clAddr_C),
        .addr  (wr_addr),
        .last  (last)
    );

`ifdef BUF2MPF_WRFENCE_EN
    logic fence_pending;
    logic fence_rcvd;
    logic fence_rsp;

    assign fence_issue = (state == DRAIN) && fence_pending
                      && !mpf.c1TxAlmFull;
    assign fence_rsp   = cci_c1Rx_isWriteFenceRsp(mpf.c1Rx)
                      && (mpf.c1Rx.mdata == tag);
    assign complete    = requests_done && !mpf.c1TxValid
                      && (nwr_resp == nwr_rq)
                      && !fence_pending && fence_rcvd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fence_pending <= 1'b0;
            fence_rcvd    <= 1'b0;
        end else if (start) begin
            fence_pending <= 1'b0;
            fence_rcvd    <= zero_dim;
        end else begin
            if (issue && last)
                fence_pending <= 1'b1;
            else if (fence_issue)
                fence_pending <= 1'b0;
            if (fence_rsp && state != IDLE)
                fence_rcvd <= 1'b1;
        end
    end
`else
    assign fence_issue = 1'b0;
    // the in-flight last write is not yet in nwr_rq, hence !c1TxValid
    assign complete    = requests_done && !mpf.c1TxValid
                      && (nwr_resp == nwr_rq);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (run) state_nxt = zero_dim ? DRAIN : RUN;
            RUN:     if (issue && last) state_nxt = DRAIN;
            DRAIN:   if (complete) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nwr_rq        <= '0;
            nwr_resp      <= '0;
            requests_done <= 1'b0;
        end else if (start) begin
            nwr_rq        <= '0;
            nwr_resp      <= '0;
            requests_done <= zero_dim;
        end else begin
            if (issue && last)
                requests_done <= 1'b1;
            if (mpf.c1TxValid && !tx_is_fence)
                nwr_rq <= nwr_rq + 32'd1;
            if (wr_rsp && state != IDLE)
                nwr_resp <= nwr_resp + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mpf.c1TxValid <= 1'b0;
            mpf.reqMemHdr <= '0;
            mpf.c1TxData  <= '0;
            tx_is_fence   <= 1'b0;
        end else begin
            mpf.c1TxValid <= issue || fence_issue;
            tx_is_fence   <= fence_issue;
            if (issue) begin
                mpf.reqMemHdr <= mk_wr_hdr(wr_addr, tag);
                mpf.c1TxData  <= mpf.buffer_data;
            end else if (fence_issue) begin
                mpf.reqMemHdr <= mk_fence_hdr(tag);
            end
        end
    end

endmodule

// File: tb/tb_buffer_to_mpf_sm_matrix.sv
// Directed bench for buffer_to_mpf_sm_matrix: vector table plus
// hand-written AlmFull, empty-buffer, reset and fence sequences.
module tb_buffer_to_mpf_sm_matrix;
    import matrix_mult_pkg::*;

    localparam int WR_MDATA = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] M;
    logic [31:0] N;
    t_cci_clAddr base;
    logic        done;

    buffer_to_mpf_sm_matrix_if mpf();

    buffer_to_mpf_sm_matrix #(.WR_MDATA(WR_MDATA)) dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .M              (M),
        .N              (N),
        .first_clAddr_C (base),
        .done           (done),
        .mpf            (mpf)
    );

    always #5 clk = ~clk;

    typedef struct {
        t_cci_mpf_c1_ReqMemHdr hdr;
        t_cci_clData           data;
    } wr_t;

    typedef struct {
        int         due;
        bit         fence;
        t_cci_mdata md;
    } rsp_t;

    typedef struct {
        logic [31:0] m;
        logic [31:0] n;
        t_cci_clAddr b;
        int          nlines;
        int          done_max;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int wr_rsp_given = 0;
    int fence_rsp_given = 0;
    int fence_cnt = 0;
    int wr_lat = 3;
    int fence_lat = 3;
    bit resp_en = 1'b1;
    logic af_prev = 1'b0;
    logic done_s = 1'b0;
    t_cci_mpf_c1_ReqMemHdr fence_hdr;

    wr_t         wr_log[$];
    rsp_t        rsp_q[$];
    t_cci_clData buf_q[$];
    t_cci_clData pushed[$];
    vec_t        vecs[7];

    function automatic void chk(string nm, logic [63:0] act,
                                logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void chk_w(string nm, logic [511:0] act,
                                  logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    task automatic refresh();
        mpf.buffer_empty = (buf_q.size() == 0);
        mpf.buffer_data  = (buf_q.size() != 0) ? buf_q[0] : '0;
    endtask

    task automatic push_line(input t_cci_clData d);
        buf_q.push_back(d);
        pushed.push_back(d);
        refresh();
    endtask

    // One clock: observe at negedge, then update stimulus 1 after posedge.
    task automatic cyc();
        bit   will_pop;
        rsp_t r;
        @(negedge clk);
        done_s   = done;
        will_pop = mpf.buffer_rd_enable;
        if (mpf.buffer_empty)
            chk("no_pop_when_empty", 64'(will_pop), 64'd0);
        if (mpf.c1TxAlmFull)
            chk("no_pop_when_almfull", 64'(will_pop), 64'd0);
        if (af_prev)
            chk("no_valid_after_almfull", 64'(mpf.c1TxValid), 64'd0);
        af_prev = mpf.c1TxAlmFull;
        if (mpf.c1TxValid) begin
            r.md = mpf.reqMemHdr.mdata;
            if (mpf.reqMemHdr.req_type == eREQ_WRFENCE) begin
                fence_cnt++;
                fence_hdr = mpf.reqMemHdr;
                r.fence = 1'b1;
                r.due   = cyc_cnt + fence_lat;
            end else begin
                wr_log.push_back('{hdr: mpf.reqMemHdr, data: mpf.c1TxData});
                r.fence = 1'b0;
                r.due   = cyc_cnt + wr_lat;
            end
            rsp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        cyc_cnt++;
        if (will_pop && buf_q.size() > 0)
            void'(buf_q.pop_front());
        refresh();
        mpf.c1Rx = '0;
        if (resp_en && rsp_q.size() > 0 && rsp_q[0].due <= cyc_cnt) begin
            r = rsp_q.pop_front();
            mpf.c1Rx.rspValid  = 1'b1;
            mpf.c1Rx.resp_type = r.fence ? eRSP_WRFENCE : eRSP_WRLINE;
            mpf.c1Rx.mdata     = r.md;
            if (r.md == t_cci_mdata'(WR_MDATA)) begin
                if (r.fence) fence_rsp_given++;
                else         wr_rsp_given++;
            end
        end
    endtask

    task automatic start(input logic [31:0] m, input logic [31:0] n,
                         input t_cci_clAddr b);
        M = m;
        N = n;
        base = b;
        run = 1'b1;
        cyc();
        run = 1'b0;
    endtask

    task automatic clear_logs();
        wr_log.delete();
        pushed.delete();
        wr_rsp_given = 0;
        fence_rsp_given = 0;
        fence_cnt = 0;
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (n < bound) begin
            cyc();
            n++;
            if (done_s) break;
        end
        chk("done_within_bound", 64'(done_s), 64'd1);
    endtask

    task automatic check_log(input string tag, input t_cci_clAddr b,
                             input int n);
        t_cci_mpf_c1_ReqMemHdr e;
        chk({tag, "_count"}, 64'(wr_log.size()), 64'(n));
        for (int i = 0; i < n && i < wr_log.size(); i++) begin
            e = '0;
            e.vc_sel          = eVC_VA;
            e.sop             = 1'b1;
            e.cl_len          = eCL_LEN_1;
            e.req_type        = eREQ_WRLINE_M;
            e.addr_is_virtual = 1'b1;
            e.address         = b + t_cci_clAddr'(i);
            e.mdata           = t_cci_mdata'(WR_MDATA);
            chk_w($sformatf("%s_hdr%0d", tag, i),
                  512'(wr_log[i].hdr), 512'(e));
            chk_w($sformatf("%s_data%0d", tag, i),
                  wr_log[i].data, pushed[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nc;
        int   exp_f;
        rsp_t bogus;

        vecs[0] = '{32'd2, 32'd32, 42'h1000, 4, 0};
        vecs[1] = '{32'd3, 32'd16, 42'h2000, 3, 0};
        vecs[2] = '{32'd1, 32'd47, 42'h3ff, 2, 0};
        vecs[3] = '{32'd0, 32'd64, 42'h40, 0, 2};
        vecs[4] = '{32'd2, 32'd0, 42'h40, 0, 2};
        vecs[5] = '{32'd1, 32'd32, 42'h3ff_ffff_ffff, 2, 0};
        vecs[6] = '{32'd2, 32'd48, 42'h8000, 6, 0};

        reset = 1'b1;
        run = 1'b0;
        M = '0;
        N = '0;
        base = '0;
        mpf.c1TxAlmFull = 1'b0;
        mpf.c1Rx = '0;
        refresh();
        cyc();
        cyc();
        chk("rst_done", 64'(done), 64'd1);
        chk("rst_valid", 64'(mpf.c1TxValid), 64'd0);
        chk("rst_hdr", 64'(mpf.reqMemHdr.address), 64'd0);
        chk_w("rst_data", mpf.c1TxData, '0);
        chk("rst_rd_en", 64'(mpf.buffer_rd_enable), 64'd0);
        reset = 1'b0;
        cyc();

        for (int v = 0; v < 7; v++) begin
            clear_logs();
            for (int i = 0; i < vecs[v].nlines; i++)
                push_line({16{32'((v << 16) | i)}});
            start(vecs[v].m, vecs[v].n, vecs[v].b);
            wait_done(200, nc);
            if (vecs[v].done_max != 0)
                chk($sformatf("v%0d_done_latency", v),
                    64'(nc <= vecs[v].done_max), 64'd1);
            check_log($sformatf("v%0d", v), vecs[v].b, vecs[v].nlines);
            chk($sformatf("v%0d_rsp_before_done", v),
                64'(wr_rsp_given), 64'(vecs[v].nlines));
            chk($sformatf("v%0d_buffer_drained", v),
                64'(buf_q.size()), 64'd0);
`ifdef BUF2MPF_WRFENCE_EN
            exp_f = (vecs[v].nlines > 0) ? 1 : 0;
`else
            exp_f = 0;
`endif
            chk($sformatf("v%0d_fences", v), 64'(fence_cnt), 64'(exp_f));
            cyc();
        end

        // AlmFull held high for 5 cycles in the middle of a transfer
        clear_logs();
        for (int i = 0; i < 4; i++)
            push_line({16{32'(32'hA0000 | i)}});
        start(32'd2, 32'd32, 42'h6000);
        cyc();
        mpf.c1TxAlmFull = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        chk("af_partial", 64'(wr_log.size() < 4), 64'd1);
        mpf.c1TxAlmFull = 1'b0;
        wait_done(200, nc);
        check_log("af", 42'h6000, 4);

        // buffer runs dry after one line; run re-pulsed while busy
        clear_logs();
        push_line({16{32'h0B0B_0000}});
        start(32'd3, 32'd16, 42'h7000);
        for (int i = 0; i < 4; i++) cyc();
        run = 1'b1;
        cyc();
        run = 1'b0;
        bogus.due = cyc_cnt;
        bogus.fence = 1'b0;
        bogus.md = 16'd5;
        rsp_q.push_back(bogus);
        for (int i = 0; i < 5; i++) cyc();
        chk("empty_one_written", 64'(wr_log.size()), 64'd1);
        chk("empty_not_done", 64'(done_s), 64'd0);
        push_line({16{32'h0B0B_0001}});
        push_line({16{32'h0B0B_0002}});
        wait_done(200, nc);
        check_log("empty", 42'h7000, 3);

        // asynchronous reset with writes outstanding
        clear_logs();
        resp_en = 1'b0;
        for (int i = 0; i < 4; i++)
            push_line({16{32'(32'hC0000 | i)}});
        start(32'd4, 32'd16, 42'h9000);
        nc = 0;
        while (wr_log.size() < 2 && nc < 20) begin
            cyc();
            nc++;
        end
        chk("rst_two_outstanding", 64'(wr_log.size() >= 2), 64'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_valid", 64'(mpf.c1TxValid), 64'd0);
        chk_w("arst_hdr", 512'(mpf.reqMemHdr), '0);
        chk_w("arst_data", mpf.c1TxData, '0);
        chk("arst_done", 64'(done), 64'd1);
        chk("arst_rd_en", 64'(mpf.buffer_rd_enable), 64'd0);
        cyc();
        cyc();
        reset = 1'b0;
        buf_q.delete();
        refresh();
        resp_en = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        chk("stale_rsp_idle", 64'(done_s), 64'd1);
        chk("stale_rsp_drained", 64'(rsp_q.size()), 64'd0);
        clear_logs();
        push_line({16{32'h0D0D_0001}});
        start(32'd1, 32'd16, 42'h5000);
        wait_done(200, nc);
        check_log("post_rst", 42'h5000, 1);

`ifdef BUF2MPF_WRFENCE_EN
        // done must wait for the fence response, not just the write's
        clear_logs();
        fence_lat = 15;
        push_line({16{32'h0E0E_0001}});
        start(32'd1, 32'd16, 42'hA000);
        nc = 0;
        while (wr_rsp_given < 1 && nc < 40) begin
            cyc();
            nc++;
        end
        cyc();
        cyc();
        chk("fence_wr_rsp_seen", 64'(wr_rsp_given), 64'd1);
        chk("fence_done_waits", 64'(done_s), 64'd0);
        chk("fence_issued", 64'(fence_cnt), 64'd1);
        chk("fence_type", 64'(fence_hdr.req_type), 64'(eREQ_WRFENCE));
        chk("fence_mdata", 64'(fence_hdr.mdata), 64'(WR_MDATA));
        wait_done(200, nc);
        chk("fence_rsp_before_done", 64'(fence_rsp_given), 64'd1);
        check_log("fence", 42'hA000, 1);
        fence_lat = 3;
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
